// File: rtl/hls_mul_pkg.sv
// Shared constants, tags and helpers for the pipelined multiply/MAC operator.
// Imported by the interface-side datapath and the tag pipeline.
package hls_mul_pkg;

    localparam int NUM_STAGE_MIN = 1;
    localparam int NUM_STAGE_MAX = 4;

    typedef struct packed {
        logic vld;
        logic acc_en;
        logic acc_clr;
    } tag_t;

    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1 + 1;
    endfunction

    // Extra top bit: copy of the MSB for signed operands, zero otherwise.
    function automatic logic ext_bit(input logic msb, input logic is_signed);
        return is_signed & msb;
    endfunction

endpackage

// File: rtl/hls_mul_pipe_if.sv
// Operand/result bundle of the multiply/MAC operator.
// master drives operands and tags; slave returns the result.
interface hls_mul_pipe_if #(
    parameter int din0_WIDTH = 8,
    parameter int din1_WIDTH = 4,
    parameter int dout_WIDTH = 8
);
    logic                  ce;
    logic                  din_vld;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  sign0;
    logic                  sign1;
    logic                  acc_en;
    logic                  acc_clr;
    logic [dout_WIDTH-1:0] dout;
    logic                  dout_vld;

    modport master (
        output ce, din_vld, din0, din1,
        output sign0, sign1, acc_en, acc_clr,
        input  dout, dout_vld
    );

    modport slave (
        input  ce, din_vld, din0, din1,
        input  sign0, sign1, acc_en, acc_clr,
        output dout, dout_vld
    );
endinterface

// File: rtl/hls_mul_tag_pipe.sv
// Valid/accumulate tag shift register, DEPTH stages, ce-gated, sync reset.
// Exposes the tag entering the last stage and the last-stage valid.
module hls_mul_tag_pipe
    import hls_mul_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  tag_t tag_in,
    output tag_t tag_pen,
    output logic vld_out
);

    logic vld_q;

    if (DEPTH == 1) begin : g_direct
        assign tag_pen = tag_in;
    end else begin : g_shift
        tag_t sr [DEPTH-1];

        // shift tags towards the final stage; reset drops in-flight items
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH - 1; i++) sr[i] <= '0;
            end else if (ce) begin
                sr[0] <= tag_in;
                for (int i = 1; i < DEPTH - 1; i++) sr[i] <= sr[i-1];
            end
        end

        assign tag_pen = sr[DEPTH-2];
    end

    // last stage only needs the valid bit; it is the output strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= 1'b0;
        end else if (ce) begin
            vld_q <= tag_pen.vld;
        end
    end

    assign vld_out = vld_q;

endmodule

// File: rtl/hls_mul_pipe.sv
// Pipelined multiply / multiply-accumulate with run-time signedness.
// Stage 1 operands, middle product retiming, final accumulate/output.
module hls_mul_pipe
    import hls_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 8,
    parameter int din1_WIDTH = 4,
    parameter int dout_WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    hls_mul_pipe_if.slave bus
);

    localparam int PW = prod_width(din0_WIDTH, din1_WIDTH);

    if (ID < 0 || NUM_STAGE < NUM_STAGE_MIN ||
        NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_param
        $error("hls_mul_pipe: illegal parameter");
    end

    logic signed [din0_WIDTH:0] op0_n;
    logic signed [din0_WIDTH:0] op0;
    logic signed [din1_WIDTH:0] op1_n;
    logic signed [din1_WIDTH:0] op1;
    logic signed [PW-1:0]       prod;
    logic signed [PW-1:0]       prod_fin;
    logic [dout_WIDTH-1:0]      res;
    logic [dout_WIDTH-1:0]      sum;
    logic [dout_WIDTH-1:0]      acc;
    logic [dout_WIDTH-1:0]      dout_q;
    tag_t                       tag_in;
    tag_t                       tag_pen;
    logic                       vld_out;

    assign op0_n = {ext_bit(bus.din0[din0_WIDTH-1], bus.sign0), bus.din0};
    assign op1_n = {ext_bit(bus.din1[din1_WIDTH-1], bus.sign1), bus.din1};

    if (NUM_STAGE == 1) begin : g_op_comb
        assign op0 = op0_n;
        assign op1 = op1_n;
    end else begin : g_op_reg
        // stage 1 operand registers
        always_ff @(posedge clk) begin
            if (bus.ce) begin
                op0 <= op0_n;
                op1 <= op1_n;
            end
        end
    end

    // exact: the widest signed/unsigned product fits in PW bits
    assign prod = PW'(op0) * PW'(op1);

    if (NUM_STAGE <= 2) begin : g_prod_comb
        assign prod_fin = prod;
    end else begin : g_prod_reg
        logic signed [PW-1:0] pr [NUM_STAGE-2];

        // product retiming across the middle stages
        always_ff @(posedge clk) begin
            if (bus.ce) begin
                pr[0] <= prod;
                for (int i = 1; i < NUM_STAGE - 2; i++) pr[i] <= pr[i-1];
            end
        end

        assign prod_fin = pr[NUM_STAGE-3];
    end

    // signed cast: truncates, or sign-extends when dout is wider than P
    assign res = dout_WIDTH'(prod_fin);
    assign sum = acc + res;

    assign tag_in = '{vld: bus.din_vld,
                      acc_en: bus.acc_en,
                      acc_clr: bus.acc_clr};

    hls_mul_tag_pipe #(
        .DEPTH(NUM_STAGE)
    ) u_tags (
        .clk    (clk),
        .reset  (reset),
        .ce     (bus.ce),
        .tag_in (tag_in),
        .tag_pen(tag_pen),
        .vld_out(vld_out)
    );

    // final stage: accumulator update and output register; clear wins
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            dout_q <= '0;
        end else if (bus.ce && tag_pen.vld) begin
            unique case ({tag_pen.acc_en, tag_pen.acc_clr})
                2'b00: dout_q <= res;
                2'b01: begin
                    dout_q <= res;
                    acc    <= '0;
                end
                2'b11: begin
                    dout_q <= res;
                    acc    <= res;
                end
                default: begin
                    dout_q <= sum;
                    acc    <= sum;
                end
            endcase
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = vld_out;

endmodule

// File: tb/tb_hls_mul_pipe.sv
// Bench for hls_mul_pipe: vector table, hand sequences, random vs model.
// Each enabled edge is checked against an ordered queue of due results.
module tb_hls_mul_pipe;

    localparam int NS = 3;
    localparam int W0 = 8;
    localparam int W1 = 4;
    localparam int WO = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hls_mul_pipe_if #(
        .din0_WIDTH(W0),
        .din1_WIDTH(W1),
        .dout_WIDTH(WO)
    ) bus ();

    hls_mul_pipe #(
        .ID        (1),
        .NUM_STAGE (NS),
        .din0_WIDTH(W0),
        .din1_WIDTH(W1),
        .dout_WIDTH(WO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int         due;
        logic [7:0] val;
    } exp_t;

    typedef struct {
        logic [7:0] d0;
        logic [3:0] d1;
        logic       s0;
        logic       s1;
        logic       ae;
        logic       ac;
        logic [7:0] res;
    } vec_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    int         en_cnt = 0;
    logic [7:0] m_acc = 8'd0;
    vec_t       tab[13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // reference: integer product of the interpreted operands, mod 256
    task automatic model(input logic [7:0] d0, input logic [3:0] d1,
                         input logic s0, input logic s1,
                         input logic ae, input logic ac,
                         output logic [7:0] out);
        int v0;
        int v1;
        int p;
        logic [7:0] r;
        v0 = s0 ? int'($signed(d0)) : int'(d0);
        v1 = s1 ? int'($signed(d1)) : int'(d1);
        p = v0 * v1;
        r = p[7:0];
        if (ac) begin
            m_acc = ae ? r : 8'd0;
            out = r;
        end else if (ae) begin
            m_acc = m_acc + r;
            out = m_acc;
        end else begin
            out = r;
        end
    endtask

    task automatic drive(input logic ce, input logic vld,
                         input logic [7:0] d0, input logic [3:0] d1,
                         input logic s0, input logic s1,
                         input logic ae, input logic ac);
        bus.ce = ce;
        bus.din_vld = vld;
        bus.din0 = d0;
        bus.din1 = d1;
        bus.sign0 = s0;
        bus.sign1 = s1;
        bus.acc_en = ae;
        bus.acc_clr = ac;
    endtask

    task automatic idle(input logic ce);
        drive(ce, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // one clock: enqueue accepted item, then check what the edge produced
    task automatic cyc(input bit use_t, input logic [7:0] texp);
        logic en;
        logic [7:0] pd;
        logic pv;
        logic [7:0] mo;
        exp_t e;
        en = bus.ce && !reset;
        pd = bus.dout;
        pv = bus.dout_vld;
        if (en && bus.din_vld) begin
            model(bus.din0, bus.din1, bus.sign0, bus.sign1,
                  bus.acc_en, bus.acc_clr, mo);
            e.due = en_cnt + NS;
            e.val = use_t ? texp : mo;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
            m_acc = 8'd0;
            chk("rst_vld", 32'(bus.dout_vld), 32'd0);
            chk("rst_dout", 32'(bus.dout), 32'd0);
        end else if (en) begin
            en_cnt++;
            if (q.size() > 0 && q[0].due == en_cnt) begin
                chk("out_vld", 32'(bus.dout_vld), 32'd1);
                chk("out_dout", 32'(bus.dout), 32'(q[0].val));
                q.delete(0);
            end else begin
                chk("idle_vld", 32'(bus.dout_vld), 32'd0);
                chk("idle_dout", 32'(bus.dout), 32'(pd));
            end
        end else begin
            chk("hold_vld", 32'(bus.dout_vld), 32'(pv));
            chk("hold_dout", 32'(bus.dout), 32'(pd));
        end
    endtask

    initial begin
        tab = '{
            '{8'h9C, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 8'hD4},
            '{8'hFF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF1},
            '{8'hFF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01},
            '{8'hFF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF1},
            '{8'h02, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h06},
            '{8'h02, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0C},
            '{8'h02, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h12},
            '{8'h02, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h18},
            '{8'h64, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h64},
            '{8'h64, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC8},
            '{8'h64, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h90},
            '{8'h01, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01},
            '{8'h01, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h91}
        };

        reset = 1'b1;
        idle(1'b1);
        cyc(0, 8'h00);
        cyc(0, 8'h00);
        reset = 1'b0;
        cyc(0, 8'h00);

        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 1'b1, tab[i].d0, tab[i].d1, tab[i].s0,
                  tab[i].s1, tab[i].ae, tab[i].ac);
            cyc(1, tab[i].res);
        end
        idle(1'b1);
        repeat (NS + 1) cyc(0, 8'h00);

        drive(1'b1, 1'b1, 8'h9C, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1, 8'hD4);
        drive(1'b0, 1'b1, 8'h11, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc(0, 8'h00);
        idle(1'b1);
        cyc(0, 8'h00);
        cyc(0, 8'h00);
        idle(1'b0);
        cyc(0, 8'h00);
        chk("stall_vld_held", 32'(bus.dout_vld), 32'd1);
        chk("stall_dout_held", 32'(bus.dout), 32'hD4);
        idle(1'b1);
        repeat (2) cyc(0, 8'h00);

        drive(1'b1, 1'b1, 8'h05, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(0, 8'h00);
        drive(1'b1, 1'b1, 8'h07, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(0, 8'h00);
        reset = 1'b1;
        drive(1'b1, 1'b1, 8'h09, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(0, 8'h00);
        reset = 1'b0;
        idle(1'b1);
        repeat (4) cyc(0, 8'h00);
        drive(1'b1, 1'b1, 8'h01, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1, 8'h01);
        idle(1'b1);
        repeat (NS + 1) cyc(0, 8'h00);

        repeat (400) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom),
                  8'($urandom), 4'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom),
                  $urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 99) == 0);
            cyc(0, 8'h00);
        end
        reset = 1'b0;
        idle(1'b1);
        repeat (NS + 1) cyc(0, 8'h00);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hls_mul_pipe.md
# hls_mul_pipe

Parametrised, pipelined integer multiply/multiply-accumulate operator for HLS-generated datapaths. It is the latency-configurable successor to the single-cycle `mul_<w0><s>_<w1><s>` operators. It adds run-time operand signedness, valid tracking through the pipeline, clock enable, and an optional accumulator at the final stage. The scheduler instantiates it wherever a multiply is given `NUM_STAGE >= 1`.

## Interface
- `ID`, default 1: instance tag from the scheduler; no functional effect.
- `NUM_STAGE`, default 3: latency in ce-qualified cycles; legal range 1..4.
- `din0_WIDTH`, default 8: width of operand 0.
- `din1_WIDTH`, default 4: width of operand 1.
- `dout_WIDTH`, default 8: width of the result and of the accumulator.

Ports, clock and reset first:
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high; overrides `ce`.
- `ce`, in, 1: clock enable; when 0, every register holds.
- `din_vld`, in, 1: an input item is present.
- `din0`, in, `din0_WIDTH`: operand 0.
- `din1`, in, `din1_WIDTH`: operand 1.
- `sign0`, in, 1: 1 means `din0` is two's complement; 0 means unsigned.
- `sign1`, in, 1: the same, for `din1`.
- `acc_en`, in, 1: the item takes part in accumulation.
- `acc_clr`, in, 1: the item restarts the accumulator.
- `dout`, out, `dout_WIDTH`: result.
- `dout_vld`, out, 1: single-cycle pulse, one per accepted item.

## Operation
- **Acceptance:** an item is accepted on an edge where `ce=1`, `din_vld=1` and `reset=0`. The tags `sign0`, `sign1`, `acc_en` and `acc_clr` travel with the item.
- **Operand extension:** each operand is extended by one bit. The MSB is replicated when its sign bit is 1; otherwise a 0 is prepended.
- **Product:** P is the signed product, `din0_WIDTH+din1_WIDTH+1` bits wide, exact for every signedness mix.
- **Result R:** the low `dout_WIDTH` bits of P. When `dout_WIDTH` exceeds the P width, P is sign-extended. There is no saturation.
- **Final stage:** accumulator register A has width `dout_WIDTH`. For each valid item:
  - `acc_en=0`, `acc_clr=0`: `dout`=R; A unchanged.
  - `acc_en=0`, `acc_clr=1`: `dout`=R; A←0.
  - `acc_en=1`, `acc_clr=1`: `dout`=R; A←R.
  - `acc_en=1`, `acc_clr=0`: `dout`=A+R; A←A+R, wrapping modulo 2^`dout_WIDTH`.
- **Idle output:** `dout` holds its last value between valid items. `dout_vld` is 0 on any cycle with no item completing.
- **Back-to-back accumulation:** A is updated in the same cycle it is read. Consecutive accumulating items see each other's sums with no bubbles.

## Timing
- **Latency:** an item accepted at ce-edge k produces `dout`/`dout_vld` registered at ce-edge k+`NUM_STAGE-1`. Output is therefore visible after exactly `NUM_STAGE` enabled edges, counting the accepting edge as the first.
- **Throughput:** one item per ce-enabled cycle.
- **`ce=0`:** freezes data, valid bits, A, `dout` and `dout_vld`. A `dout_vld` that is high stays high until the next enabled edge, so downstream must qualify it with `ce`.
- **Reset:** on the reset edge all pipeline valid bits, A and `dout` go to 0 and `dout_vld` goes to 0. In-flight items are discarded and produce no output. Inputs presented on the reset edge are ignored.
- **`acc_clr` with `acc_en`:** on the same item, clear wins: A is loaded with R, not A+R.
- **`NUM_STAGE=1`:** a single registered stage; operand register, multiply and accumulate share one cycle.

## Structure
- **Package `hls_mul_pkg`:** `NUM_STAGE_MIN`=1, `NUM_STAGE_MAX`=4, a product-width function (`w0+w1+1`) and an operand-extension function.
- **Sub-module `hls_mul_tag_pipe`:** a parametrised shift register of depth `NUM_STAGE` carrying valid and the accumulate tags, with ce/reset semantics matching the datapath.
- **Datapath:**
  - Operand registers at stage 1.
  - Product retiming registers across the middle stages.
  - Accumulate and output register at the final stage.

## Test plan
All scenarios use `din0_WIDTH=8`, `din1_WIDTH=4`, `dout_WIDTH=8`, `NUM_STAGE=3`.
- **Signed:** `din0`=0x9C, `din1`=0x3, `sign0`=`sign1`=1 → `dout`=0xD4 (−300 truncated), `dout_vld` on the 3rd enabled edge.
- **Signedness mix:** operands 0xFF and 0xF.
  - Unsigned/unsigned → 0xF1.
  - Signed/signed → 0x01.
  - Signed/unsigned → 0xF1.
  - Issue all three back-to-back → three consecutive `dout_vld` pulses in that order.
- **ce stall:** accept an item, then hold `ce`=0 for 5 cycles → `dout_vld` appears only after 2 further enabled edges, with the value unchanged.
- **Accumulate:** four back-to-back 2×3 items, the first with `acc_en`=1 and `acc_clr`=1, the rest with `acc_en`=1 → `dout` = 0x06, 0x0C, 0x12, 0x18.
- **Wrap and pass-through:**
  - Accumulating 100×1 then 100×1 → 0xC8.
  - Then 100×2 → wraps to 0x90 (200+200−256).
  - A following `acc_en`=0 item 1×1 → `dout`=0x01 with A unchanged; the next accumulating 1×1 → 0x91.
- **Reset mid-flight:** three items in flight, assert `reset` for 1 cycle → no `dout_vld`, `dout`=0, A=0. The next accumulating item 1×1 with `acc_clr`=0 → 0x01.
